// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, byte/half/word accesses with
// misalignment faults, a memory-side ack timeout and a held response handshake.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, RESP = 2'd2} state_t;

    function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic f;
        case (f3)
            3'b000:  f = 1'b0;
            3'b001:  f = off[0];
            3'b010:  f = (off != 2'b00);
            3'b100:  f = we;
            3'b101:  f = we | off[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << off;
            3'b001:  s = off[1] ? 4'b1100 : 4'b0011;
            3'b010:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{wd[7:0]}};
            3'b001:  d = {2{wd[15:0]}};
            3'b010:  d = wd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] d;
        case (off)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            2'd3:    b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  d = {{24{b[7]}}, b};
            3'b100:  d = {24'h00_0000, b};
            3'b001:  d = {{16{h[15]}}, h};
            3'b101:  d = {16'h0000, h};
            3'b010:  d = rd;
            default: d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        we_r, we_s;
    logic [2:0]  funct3_r, funct3_s;
    logic [1:0]  off_r, off_s;
    logic [4:0]  rd_r, rd_s;
    logic        req_ready_r, req_ready_s;
    logic        mem_req_r, mem_req_s, mem_we_r, mem_we_s;
    logic [29:0] mem_addr_r, mem_addr_s;
    logic [3:0]  mem_wstrb_r, mem_wstrb_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic        resp_valid_r, resp_valid_s, resp_fault_r, resp_fault_s;
    logic [31:0] resp_rdata_r, resp_rdata_s;
    logic [4:0]  resp_rd_r, resp_rd_s;
    logic        ack_s;

    assign ack_s = mem_ack & mem_req_r;

    // Next-state and next-output decode; every output is registered.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        we_s         = we_r;
        funct3_s     = funct3_r;
        off_s        = off_r;
        rd_s         = rd_r;
        req_ready_s  = req_ready_r;
        mem_req_s    = mem_req_r;
        mem_we_s     = mem_we_r;
        mem_addr_s   = mem_addr_r;
        mem_wstrb_s  = mem_wstrb_r;
        mem_wdata_s  = mem_wdata_r;
        resp_valid_s = resp_valid_r;
        resp_fault_s = resp_fault_r;
        resp_rdata_s = resp_rdata_r;
        resp_rd_s    = resp_rd_r;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    we_s        = req_we;
                    funct3_s    = req_funct3;
                    off_s       = req_addr[1:0];
                    rd_s        = req_rd;
                    req_ready_s = 1'b0;
                    cnt_s       = 8'd0;
                    if (is_fault(req_we, req_funct3, req_addr[1:0])) begin
                        state_s      = RESP;
                        resp_valid_s = 1'b1;
                        resp_fault_s = 1'b1;
                        resp_rdata_s = 32'h0000_0000;
                        resp_rd_s    = req_rd;
                    end else begin
                        state_s     = MEM;
                        mem_req_s   = 1'b1;
                        mem_we_s    = req_we;
                        mem_addr_s  = req_addr[31:2];
                        mem_wstrb_s = req_we ? store_strobe(req_funct3, req_addr[1:0]) : 4'b0000;
                        mem_wdata_s = req_we ? store_data(req_funct3, req_wdata) : 32'h0000_0000;
                    end
                end else begin
                    req_ready_s = 1'b1;
                end
            end
            MEM: begin
                if (ack_s || (cnt_r == 8'(TIMEOUT - 1))) begin
                    state_s      = RESP;
                    mem_req_s    = 1'b0;
                    mem_we_s     = 1'b0;
                    mem_addr_s   = 30'd0;
                    mem_wstrb_s  = 4'b0000;
                    mem_wdata_s  = 32'h0000_0000;
                    resp_valid_s = 1'b1;
                    resp_rd_s    = rd_r;
                    resp_fault_s = ~ack_s;
                    resp_rdata_s = (ack_s && !we_r) ? load_data(funct3_r, off_r, mem_rdata)
                                                    : 32'h0000_0000;
                    cnt_s        = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_s      = IDLE;
                    req_ready_s  = 1'b1;
                    resp_valid_s = 1'b0;
                    resp_fault_s = 1'b0;
                    resp_rdata_s = 32'h0000_0000;
                    resp_rd_s    = 5'd0;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s      = IDLE;
                cnt_s        = 8'd0;
                req_ready_s  = 1'b0;
                mem_req_s    = 1'b0;
                mem_we_s     = 1'b0;
                mem_addr_s   = 30'd0;
                mem_wstrb_s  = 4'b0000;
                mem_wdata_s  = 32'h0000_0000;
                resp_valid_s = 1'b0;
                resp_fault_s = 1'b0;
                resp_rdata_s = 32'h0000_0000;
                resp_rd_s    = 5'd0;
            end
        endcase
    end

    // State, latched request fields and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            cnt_r        <= 8'd0;
            we_r         <= 1'b0;
            funct3_r     <= 3'b000;
            off_r        <= 2'b00;
            rd_r         <= 5'd0;
            req_ready_r  <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 30'd0;
            mem_wstrb_r  <= 4'b0000;
            mem_wdata_r  <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_fault_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_rd_r    <= 5'd0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            we_r         <= we_s;
            funct3_r     <= funct3_s;
            off_r        <= off_s;
            rd_r         <= rd_s;
            req_ready_r  <= req_ready_s;
            mem_req_r    <= mem_req_s;
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wstrb_r  <= mem_wstrb_s;
            mem_wdata_r  <= mem_wdata_s;
            resp_valid_r <= resp_valid_s;
            resp_fault_r <= resp_fault_s;
            resp_rdata_r <= resp_rdata_s;
            resp_rd_r    <= resp_rd_s;
        end
    end

    assign req_ready  = req_ready_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wstrb  = mem_wstrb_r;
    assign mem_wdata  = mem_wdata_r;
    assign resp_valid = resp_valid_r;
    assign resp_fault = resp_fault_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_rd    = resp_rd_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT = 16).
module tb_load_store_unit;

    logic        clk, reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [29:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata, mem_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_fault(resp_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request and return just after its accept edge.
    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL accept_ready got=%b exp=1", req_ready);
        else pass_cnt++;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic ack_now(input logic [31:0] data);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = data;
        @(posedge clk);
        #1 mem_ack = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({req_ready, mem_req, resp_valid, resp_fault} !== 4'b0000)
            $display("FAIL reset_ctrl got=%b exp=0000", {req_ready, mem_req, resp_valid, resp_fault});
        else pass_cnt++;
        total_cnt++;
        if ({mem_we, mem_addr, mem_wstrb, mem_wdata, resp_rdata, resp_rd} !== 104'd0)
            $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wstrb, mem_wdata, resp_rdata});
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_early got=%b exp=0", req_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready_edge got=%b exp=1", req_ready);
        else pass_cnt++;
    endtask

    task automatic test_lb;
        accept(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd5);
        @(negedge clk);
        total_cnt++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, resp_valid, req_ready} !==
            {1'b1, 1'b0, 30'h40, 4'b0000, 32'h0, 1'b0, 1'b0})
            $display("FAIL lb_mem got req=%b addr=%h strb=%b exp req=1 addr=40 strb=0000",
                     mem_req, mem_addr, mem_wstrb);
        else pass_cnt++;
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({resp_valid, resp_fault, mem_req, resp_rd, resp_rdata} !==
            {1'b1, 1'b0, 1'b0, 5'd5, 32'hFFFF_FF80})
            $display("FAIL lb_resp got v=%b f=%b rd=%0d data=%h exp v=1 f=0 rd=5 data=ffffff80",
                     resp_valid, resp_fault, resp_rd, resp_rdata);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({req_ready, resp_valid} !== 2'b10)
            $display("FAIL lb_next_ready got=%b exp=10", {req_ready, resp_valid});
        else pass_cnt++;
    endtask

    task automatic test_sh;
        accept(1'b1, 3'b001, 32'h0000_0042, 32'h0000_ABCD, 5'd0);
        @(negedge clk);
        total_cnt++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !==
            {1'b1, 1'b1, 30'h10, 4'b1100, 32'hABCD_ABCD})
            $display("FAIL sh_mem got addr=%h strb=%b data=%h exp addr=10 strb=1100 data=abcdabcd",
                     mem_addr, mem_wstrb, mem_wdata);
        else pass_cnt++;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({resp_valid, resp_fault, resp_rdata} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL sh_resp got v=%b f=%b data=%h exp v=1 f=0 data=0",
                     resp_valid, resp_fault, resp_rdata);
        else pass_cnt++;
    endtask

    task automatic test_sb_stable;
        accept(1'b1, 3'b000, 32'h0000_0101, 32'h1234_5677, 5'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({mem_req, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 30'h40, 4'b0010, 32'h7777_7777})
                $display("FAIL sb_mem%0d got addr=%h strb=%b data=%h exp addr=40 strb=0010 data=77777777",
                         i, mem_addr, mem_wstrb, mem_wdata);
            else pass_cnt++;
        end
        mem_ack = 1'b1;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({resp_valid, resp_fault, resp_rd, mem_req} !== {1'b1, 1'b0, 5'd3, 1'b0})
            $display("FAIL sb_resp got v=%b f=%b rd=%0d req=%b exp 1 0 3 0",
                     resp_valid, resp_fault, resp_rd, mem_req);
        else pass_cnt++;
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3 [3]  = '{3'b001, 3'b101, 3'b100};
        logic [31:0] ad [3]  = '{32'h2, 32'h0, 32'h102};
        logic [31:0] rdt[3]  = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h80FF_1234};
        logic [31:0] exp[3]  = '{32'hFFFF_8001, 32'h0000_7FFF, 32'h0000_00FF};
        for (int i = 0; i < 3; i++) begin
            accept(1'b0, f3[i], ad[i], 32'h0, 5'd9);
            ack_now(rdt[i]);
            @(negedge clk);
            total_cnt++;
            if ({resp_valid, resp_fault, resp_rdata} !== {1'b1, 1'b0, exp[i]})
                $display("FAIL load_ext%0d got v=%b f=%b data=%h exp v=1 f=0 data=%h",
                         i, resp_valid, resp_fault, resp_rdata, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fault;
        logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3 [4] = '{3'b010, 3'b100, 3'b011, 3'b001};
        logic [31:0] ad [4] = '{32'h6, 32'h0, 32'h0, 32'h1};
        for (int i = 0; i < 4; i++) begin
            accept(we[i], f3[i], ad[i], 32'hFFFF_FFFF, 5'(i + 20));
            @(negedge clk);
            total_cnt++;
            if ({resp_valid, resp_fault, mem_req, resp_rd} !== {1'b1, 1'b1, 1'b0, 5'(i + 20)})
                $display("FAIL fault%0d got v=%b f=%b mreq=%b rd=%0d exp 1 1 0 %0d",
                         i, resp_valid, resp_fault, mem_req, resp_rd, i + 20);
            else pass_cnt++;
            total_cnt++;
            if (resp_rdata !== 32'h0) $display("FAIL fault%0d_data got=%h exp=0", i, resp_rdata);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout;
        int hi = 0;
        accept(1'b0, 3'b101, 32'h0000_0008, 32'h0, 5'd11);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) hi++;
            if (resp_valid === 1'b1) break;
        end
        total_cnt++;
        if ({resp_valid, resp_fault, resp_rdata} !== {1'b1, 1'b1, 32'h0})
            $display("FAIL timeout_resp got v=%b f=%b data=%h exp v=1 f=1 data=0",
                     resp_valid, resp_fault, resp_rdata);
        else pass_cnt++;
        total_cnt++;
        if (hi != 16) $display("FAIL timeout_len got=%0d exp=16", hi);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0;
        total_cnt++;
        if ({resp_valid, mem_req, req_ready} !== 3'b001)
            $display("FAIL timeout_late_ack got=%b exp=001", {resp_valid, mem_req, req_ready});
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        resp_ready = 1'b0;
        accept(1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd7);
        ack_now(32'hCAFE_F00D);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({resp_valid, resp_fault, req_ready, resp_rd, resp_rdata} !==
                {1'b1, 1'b0, 1'b0, 5'd7, 32'hCAFE_F00D})
                $display("FAIL bp_hold%0d got v=%b rdy=%b rd=%0d data=%h exp v=1 rdy=0 rd=7 data=cafef00d",
                         i, resp_valid, req_ready, resp_rd, resp_rdata);
            else pass_cnt++;
            if (i == 5) resp_ready = 1'b1;
        end
        @(negedge clk);
        total_cnt++;
        if ({resp_valid, req_ready} !== 2'b01)
            $display("FAIL bp_release got=%b exp=01", {resp_valid, req_ready});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int rdy = 0;
        int vld = 0;
        int bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_rd = 5'd1;
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (req_ready === 1'b1) rdy++;
            if (resp_valid === 1'b1) begin
                vld++;
                if (resp_rdata !== 32'h1122_3344) bad++;
            end
        end
        req_valid = 1'b0; mem_ack = 1'b0;
        total_cnt++;
        if (rdy != 3) $display("FAIL b2b_accepts got=%0d exp=3", rdy);
        else pass_cnt++;
        total_cnt++;
        if (vld != 3 || bad != 0) $display("FAIL b2b_resps got=%0d bad=%0d exp=3 bad=0", vld, bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        accept(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd2);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        total_cnt++;
        if ({mem_req, resp_valid, req_ready} !== 3'b000)
            $display("FAIL rst_mid_async got=%b exp=000", {mem_req, resp_valid, req_ready});
        else pass_cnt++;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL rst_mid_ready got=%b exp=1", req_ready);
        else pass_cnt++;
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1 || mem_req === 1'b1) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL rst_mid_no_resp got=%0d exp=0", seen);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
        resp_ready = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_lb();
        test_sh();
        test_sb_stable();
        test_load_ext();
        test_fault();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
